inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/tinyrv_pkg.sv | 33 +++
 rtl/inst_fetch_fifo.sv | 50 +++++
 rtl/inst_fetch.sv | 123 ++++++++++++
 tb/tb_inst_fetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tinyrv_pkg.sv
// Shared types for the tinyrv front end: fetch FSM states, fault codes and
// the instruction-buffer entry layout.
package tinyrv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_t;

  localparam logic [1:0]  FAULT_NONE       = 2'b00;
  localparam logic [1:0]  FAULT_BUS        = 2'b01;
  localparam logic [1:0]  FAULT_MISALIGN   = 2'b10;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  fault;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [31:0] pc,
                                              input logic [31:0] inst,
                                              input logic [1:0]  fault);
    fetch_entry_t e;
    e.pc    = pc;
    e.inst  = inst;
    e.fault = fault;
    return e;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Two-entry instruction buffer. A flush empties it; a push in the same cycle
// as a flush leaves exactly that one entry.
module inst_fetch_fifo
  import tinyrv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [DEPTH];
  logic         rd_ptr_reg;
  logic         wr_ptr_reg;
  logic [1:0]   count_reg;
  logic         do_pop;

  assign do_pop = pop && (count_reg != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= push;
      count_reg  <= {1'b0, push};
    end else begin
      if (push)   wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[flush ? 1'b0 : wr_ptr_reg] <= push_data;
  end

  assign head  = (count_reg != 2'd0) ? mem[rd_ptr_reg] : '0;
  assign count = count_reg;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: Wishbone classic master feeding a two-entry buffer,
// with redirect/flush, bus-error and misaligned-target fault reporting.
module inst_fetch
  import tinyrv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [1:0]  fault_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  fetch_state_t state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic [31:0]  adr_reg, adr_next;
  logic         push, flush, pop_fire, bus_active, bus_done, misaligned;
  fetch_entry_t push_data, head;
  logic [1:0]   count, occ_eff;

  assign bus_active = (state_reg == ST_BUS) || (state_reg == ST_DISCARD);
  assign bus_done   = wbm_ack_i || wbm_err_i;
  assign misaligned = (redirect_pc_i[1:0] != 2'b00);
  assign pop_fire   = inst_valid_o && inst_ready_i;
  assign occ_eff    = count - {1'b0, pop_fire};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg    <= ST_IDLE;
      fetch_pc_reg <= RESET_PC;
      adr_reg      <= 32'h0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      adr_reg      <= adr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    adr_next      = adr_reg;
    push          = 1'b0;
    push_data     = '0;
    flush         = 1'b0;
    if (redirect_i) begin
      flush         = 1'b1;
      fetch_pc_next = redirect_pc_i;
      if (misaligned) begin
        push      = 1'b1;
        push_data = make_entry(redirect_pc_i, 32'h0, FAULT_MISALIGN);
      end
      // An in-flight cycle must still be terminated before we may go quiet.
      if (bus_active && !bus_done) state_next = ST_DISCARD;
      else                         state_next = misaligned ? ST_HALT : ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (occ_eff < FULL) begin
            state_next = ST_BUS;
            adr_next   = fetch_pc_reg;
          end
        end
        ST_BUS: begin
          if (wbm_ack_i) begin
            push          = 1'b1;
            push_data     = make_entry(fetch_pc_reg, wbm_dat_i, FAULT_NONE);
            fetch_pc_next = fetch_pc_reg + 32'd4;
            if ((occ_eff + 2'd1) < FULL) adr_next = fetch_pc_reg + 32'd4;
            else                         state_next = ST_IDLE;
          end else if (wbm_err_i) begin
            push       = 1'b1;
            push_data  = make_entry(fetch_pc_reg, 32'h0, FAULT_BUS);
            state_next = ST_HALT;
          end
        end
        ST_DISCARD: begin
          // fetch_pc holds the latest redirect target; misaligned means halt.
          if (bus_done) state_next = (fetch_pc_reg[1:0] != 2'b00) ? ST_HALT : ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  inst_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop_fire),
    .flush     (flush),
    .head      (head),
    .count     (count)
  );

  assign wbm_cyc_o    = bus_active;
  assign wbm_stb_o    = bus_active;
  assign wbm_we_o     = 1'b0;
  assign wbm_sel_o    = 4'hF;
  assign wbm_adr_o    = bus_active ? adr_reg : 32'h0;
  assign inst_valid_o = (count != 2'd0);
  assign inst_o       = head.inst;
  assign pc_o         = head.pc;
  assign fault_o      = head.fault;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming, backpressure, redirects, faults,
// address wrap and asynchronous reset.
module tb_inst_fetch;

  logic        clk, rst;
  logic        cyc, stb, we, ack, err, valid, ready, redirect;
  logic [3:0]  sel;
  logic [31:0] adr, dat, inst, pc, redirect_pc;
  logic [1:0]  fault;

  logic        cyc2, stb2, we2, ack2, err2, valid2;
  logic [3:0]  sel2;
  logic [31:0] adr2, dat2, inst2, pc2;
  logic [1:0]  fault2;
  logic        ready2, redirect2;
  logic [31:0] redirect_pc2;

  logic        ack_en, err_on;
  logic [31:0] err_adr;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Simple slave: data derived from address, optional error on one address.
  assign dat  = adr ^ 32'hA5A5A5A5;
  assign err  = cyc && err_on && (adr == err_adr);
  assign ack  = cyc && ack_en && !err;
  assign dat2 = adr2 ^ 32'hA5A5A5A5;
  assign ack2 = cyc2;
  assign err2 = 1'b0;

  inst_fetch dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_i(dat), .wbm_ack_i(ack), .wbm_err_i(err),
    .inst_valid_o(valid), .inst_ready_i(ready), .inst_o(inst), .pc_o(pc),
    .fault_o(fault), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_cyc_o(cyc2), .wbm_stb_o(stb2), .wbm_we_o(we2), .wbm_sel_o(sel2),
    .wbm_adr_o(adr2), .wbm_dat_i(dat2), .wbm_ack_i(ack2), .wbm_err_i(err2),
    .inst_valid_o(valid2), .inst_ready_i(ready2), .inst_o(inst2), .pc_o(pc2),
    .fault_o(fault2), .redirect_i(redirect2), .redirect_pc_i(redirect_pc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ack_en = 1'b0; err_on = 1'b0; err_adr = 32'h0;
    ready2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = 32'h0;
    tick(); tick();

    // Reset state
    check_eq("rst_cyc",   32'(cyc),   32'd0);
    check_eq("rst_stb",   32'(stb),   32'd0);
    check_eq("rst_adr",   adr,        32'h0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_inst",  inst,       32'h0);
    check_eq("rst_pc",    pc,         32'h0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_adr2",  adr2,       32'h0);
    check_eq("we",        32'(we),    32'd0);
    check_eq("sel",       32'(sel),   32'hF);

    // Streaming with ack every cycle; dut2 exercises the address wrap
    ack_en = 1'b1; ready = 1'b1; rst = 1'b0;
    tick();
    check_eq("s_adr0",  adr,  32'h0);
    check_eq("s_cyc0",  32'(cyc), 32'd1);
    check_eq("w_adr0",  adr2, 32'hFFFF_FFF8);
    tick();
    check_eq("w_adr1",  adr2, 32'hFFFF_FFFC);
    check_eq("s_adr1",  adr,  32'h4);
    check_eq("s_valid1", 32'(valid), 32'd1);
    check_eq("s_pc1",   pc,   32'h0);
    check_eq("s_inst1", inst, 32'hA5A5A5A5);
    tick();
    check_eq("w_adr2",  adr2, 32'h0000_0000);
    check_eq("s_adr2",  adr,  32'h8);
    check_eq("s_pc2",   pc,   32'h4);
    check_eq("s_inst2", inst, 32'hA5A5A5A1);
    for (int k = 3; k <= 5; k++) begin
      tick();
      check_eq($sformatf("s_adr%0d", k),  adr,   32'(4 * k));
      check_eq($sformatf("s_valid%0d", k), 32'(valid), 32'd1);
      check_eq($sformatf("s_pc%0d", k),   pc,    32'(4 * (k - 1)));
      check_eq($sformatf("s_inst%0d", k), inst,  32'(4 * (k - 1)) ^ 32'hA5A5A5A5);
    end

    // Backpressure: two fetches fill the buffer, then the bus goes idle
    rst = 1'b1; #2; ready = 1'b0; rst = 1'b0;
    tick();
    check_eq("bp_adr0", adr, 32'h0);
    tick();
    check_eq("bp_adr1", adr, 32'h4);
    tick();
    check_eq("bp_cyc_full", 32'(cyc), 32'd0);
    tick();
    check_eq("bp_cyc_hold", 32'(cyc), 32'd0);
    check_eq("bp_pc_head",  pc, 32'h0);
    ready = 1'b1;
    tick();
    check_eq("bp_cyc_resume", 32'(cyc), 32'd1);
    check_eq("bp_adr_resume", adr, 32'h8);
    check_eq("bp_pc_after",   pc, 32'h4);

    // Redirect while a cycle is outstanding: response must be discarded
    do_reset();
    ack_en = 1'b1; ready = 1'b1;
    tick(); tick(); tick();
    check_eq("rd_adr8", adr, 32'h8);
    ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check_eq("rd_hold_adr", adr, 32'h8);
    check_eq("rd_hold_cyc", 32'(cyc), 32'd1);
    check_eq("rd_flushed",  32'(valid), 32'd0);
    tick();
    check_eq("rd_hold_adr2", adr, 32'h8);
    ack_en = 1'b1;
    tick();
    check_eq("rd_drop_cyc",   32'(cyc), 32'd0);
    check_eq("rd_drop_valid", 32'(valid), 32'd0);
    tick();
    check_eq("rd_new_adr", adr, 32'h100);
    tick();
    check_eq("rd_new_pc",   pc,   32'h100);
    check_eq("rd_new_inst", inst, 32'hA5A5A4A5);

    // Bus error at address 4
    do_reset();
    ack_en = 1'b1; ready = 1'b0; err_on = 1'b1; err_adr = 32'h4;
    tick(); tick(); tick();
    check_eq("er_cyc",   32'(cyc), 32'd0);
    check_eq("er_head_pc", pc, 32'h0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check_eq("er_pc",    pc,   32'h4);
    check_eq("er_inst",  inst, 32'h0);
    check_eq("er_fault", 32'(fault), 32'd1);
    tick();
    check_eq("er_halt_cyc", 32'(cyc), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h40; err_on = 1'b0;
    tick();
    redirect = 1'b0;
    check_eq("er_flush", 32'(valid), 32'd0);
    tick();
    check_eq("er_resume_adr", adr, 32'h40);

    // Misaligned redirect coinciding with an ack
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    check_eq("ma_valid", 32'(valid), 32'd1);
    check_eq("ma_pc",    pc,   32'h102);
    check_eq("ma_inst",  inst, 32'h0);
    check_eq("ma_fault", 32'(fault), 32'd2);
    check_eq("ma_cyc",   32'(cyc), 32'd0);
    tick(); tick();
    check_eq("ma_halt_cyc", 32'(cyc), 32'd0);
    ready = 1'b1;
    tick();
    check_eq("ma_popped", 32'(valid), 32'd0);
    tick();
    check_eq("ma_still_idle", 32'(cyc), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    tick();
    check_eq("ma_resume_adr", adr, 32'h200);

    // Asynchronous reset in the middle of a bus cycle
    ack_en = 1'b0;
    tick();
    check_eq("ar_busy", 32'(cyc), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("ar_cyc_drop", 32'(cyc), 32'd0);
    check_eq("ar_adr_zero", adr, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("ar_first_cyc", 32'(cyc), 32'd1);
    check_eq("ar_first_adr", adr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
